// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI field widths, response/burst codes and FSM encodings for the AXI SRAM slave.
package axi_sram_slave_pkg;

  localparam int unsigned IdW    = 4;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;
  localparam int unsigned StrbW  = DataW / 8;
  localparam int unsigned LenW   = 4;
  localparam int unsigned SizeW  = 3;
  localparam int unsigned BurstW = 2;
  localparam int unsigned RespW  = 2;

  localparam logic [RespW-1:0] RespOkay   = 2'b00;
  localparam logic [RespW-1:0] RespSlverr = 2'b10;

  localparam logic [BurstW-1:0] BurstFixed = 2'b00;
  localparam logic [BurstW-1:0] BurstIncr  = 2'b01;
  localparam logic [BurstW-1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {RIdle, RRd, RData} rd_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} wr_state_e;

  // Bursts wider than the data bus or with the reserved burst type never touch the RAM.
  function automatic logic burst_err(input logic [SizeW-1:0] size, input logic [BurstW-1:0] burst);
    return (size > 3'd2) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address calculator for FIXED, INCR and WRAP bursts.
module axi_burst_addr
  import axi_sram_slave_pkg::*;
(
  input  logic [AddrW-1:0]  addr_i,
  input  logic [SizeW-1:0]  size_i,
  input  logic [LenW-1:0]   len_i,
  input  logic [BurstW-1:0] burst_i,
  output logic [AddrW-1:0]  next_addr_o
);

  logic [AddrW-1:0] incr_addr;
  logic [AddrW-1:0] wrap_mask;

  always_comb begin
    incr_addr = addr_i + (AddrW'(1) << size_i);
    // Window of (len+1)<<size bytes; only the offset bits inside it may change.
    wrap_mask = ((AddrW'(len_i) + AddrW'(1)) << size_i) - AddrW'(1);
    unique case (burst_i)
      BurstIncr: next_addr_o = incr_addr;
      BurstWrap: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:   next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed RAM; independent read and write FSMs,
// one outstanding burst per direction.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned MEM_AW    = 14,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IdW-1:0]    arid,
  input  logic [AddrW-1:0]  araddr,
  input  logic [LenW-1:0]   arlen,
  input  logic [SizeW-1:0]  arsize,
  input  logic [BurstW-1:0] arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [IdW-1:0]    rid,
  output logic [DataW-1:0]  rdata,
  output logic [RespW-1:0]  rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [IdW-1:0]    awid,
  input  logic [AddrW-1:0]  awaddr,
  input  logic [LenW-1:0]   awlen,
  input  logic [SizeW-1:0]  awsize,
  input  logic [BurstW-1:0] awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [IdW-1:0]    wid,
  input  logic [DataW-1:0]  wdata,
  input  logic [StrbW-1:0]  wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [IdW-1:0]    bid,
  output logic [RespW-1:0]  bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned Depth = 1 << MEM_AW;

  logic [DataW-1:0] mem [Depth];
  logic [DataW-1:0] ram_rdata_q;

  logic unused_attr;
  assign unused_attr = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // ---------------- Read channel ----------------
  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic [IdW-1:0]    rid_q, rid_d;
  logic [AddrW-1:0]  raddr_q, raddr_d, raddr_next;
  logic [LenW-1:0]   rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [SizeW-1:0]  rsize_q, rsize_d;
  logic [BurstW-1:0] rburst_q, rburst_d;
  logic              r_final;

  axi_burst_addr u_rd_addr (
    .addr_i     (raddr_q),
    .size_i     (rsize_q),
    .len_i      (rlen_q),
    .burst_i    (rburst_q),
    .next_addr_o(raddr_next)
  );

  assign r_final = (rbeat_q == rlen_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= RIdle;
      arready_q  <= 1'b0;
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rbeat_q    <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rid_q      <= rid_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rbeat_q    <= rbeat_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RIdle:   if (arvalid && arready_q) rd_state_d = RRd;
      RRd:     rd_state_d = RData;
      RData:   if (rready) rd_state_d = r_final ? RIdle : RRd;
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rbeat_d  = rbeat_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    if (rd_state_q == RIdle && arvalid && arready_q) begin
      rid_d    = arid;
      raddr_d  = araddr;
      rlen_d   = arlen;
      rsize_d  = arsize;
      rburst_d = arburst;
      rbeat_d  = '0;
    end else if (rd_state_q == RData && rready && !r_final) begin
      raddr_d = raddr_next;
      rbeat_d = rbeat_q + 4'd1;
    end
    // arready is high exactly while the FSM sits in idle.
    arready_d = (rd_state_d == RIdle);
  end

  always_comb begin
    rvalid = (rd_state_q == RData);
    rlast  = rvalid && r_final;
    rid    = rvalid ? rid_q : '0;
    rdata  = (rvalid && !burst_err(rsize_q, rburst_q)) ? ram_rdata_q : '0;
    rresp  = (rvalid && burst_err(rsize_q, rburst_q)) ? RespSlverr : RespOkay;
  end

  assign arready = arready_q;

  // ---------------- Write channel ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic              awready_q, awready_d;
  logic [IdW-1:0]    bid_q, bid_d;
  logic [AddrW-1:0]  waddr_q, waddr_d, waddr_next;
  logic [LenW-1:0]   wlen_q, wlen_d;
  logic [LenW:0]     wbeat_q, wbeat_d;
  logic [SizeW-1:0]  wsize_q, wsize_d;
  logic [BurstW-1:0] wburst_q, wburst_d;
  logic              mismatch_q, mismatch_d;
  logic              w_in_range, mem_we;

  axi_burst_addr u_wr_addr (
    .addr_i     (waddr_q),
    .size_i     (wsize_q),
    .len_i      (wlen_q),
    .burst_i    (wburst_q),
    .next_addr_o(waddr_next)
  );

  assign w_in_range = ({1'b0, wlen_q} >= wbeat_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= WIdle;
      awready_q  <= 1'b0;
      bid_q      <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wbeat_q    <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      bid_q      <= bid_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wbeat_q    <= wbeat_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WIdle:   if (awvalid && awready_q) wr_state_d = WData;
      WData:   if (wvalid && wlast) wr_state_d = WResp;
      WResp:   if (bready) wr_state_d = WIdle;
      default: wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    bid_d      = bid_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wbeat_d    = wbeat_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    mismatch_d = mismatch_q;
    mem_we     = 1'b0;
    if (wr_state_q == WIdle && awvalid && awready_q) begin
      bid_d      = awid;
      waddr_d    = awaddr;
      wlen_d     = awlen;
      wsize_d    = awsize;
      wburst_d   = awburst;
      wbeat_d    = '0;
      mismatch_d = 1'b0;
    end else if (wr_state_q == WData && wvalid) begin
      mem_we  = w_in_range && !burst_err(wsize_q, wburst_q);
      waddr_d = waddr_next;
      // Saturate so an overlong burst can never wrap back into the legal beat range.
      wbeat_d = (wbeat_q == '1) ? wbeat_q : wbeat_q + 5'd1;
      if (!w_in_range || (wlast && wbeat_q != {1'b0, wlen_q})) mismatch_d = 1'b1;
    end
    awready_d = (wr_state_d == WIdle);
  end

  always_comb begin
    wready = (wr_state_q == WData);
    bvalid = (wr_state_q == WResp);
    bid    = bvalid ? bid_q : '0;
    bresp  = (bvalid && (mismatch_q || burst_err(wsize_q, wburst_q))) ? RespSlverr : RespOkay;
  end

  assign awready = awready_q;

  // ---------------- RAM ----------------
  // Nonblocking update gives old-data semantics on a same-cycle read/write collision.
  always_ff @(posedge clk) begin
    if (rd_state_q == RRd) ram_rdata_q <= mem[raddr_q[MEM_AW+1:2]];
    for (int b = 0; b < int'(StrbW); b++) begin
      if (mem_we && wstrb[b]) mem[waddr_q[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single-beat vector table plus burst, error and reset sequences.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(14), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  logic [1:0]  got_bresp;
  logic [3:0]  got_bid;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;   // bresp for writes, rdata for reads
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats);
    int cnt;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) timeout("aw_wait");
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) timeout("w_wait");
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    cnt = 0;
    while (!bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) timeout("b_wait");
    got_bresp = bresp;
    got_bid   = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int cnt;
    int n;
    logic [31:0] d;
    logic        l;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) timeout("ar_wait");
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_lat_1cyc", rvalid, 1'b0);
    @(negedge clk);
    chk("rvalid_lat_2cyc", rvalid, 1'b1);
    chk("rid", rid, id);
    for (int i = 0; i <= int'(len); i++) begin
      cnt = 0;
      while (!rvalid && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) timeout("r_wait");
      if (stall) begin
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
          d = rdata; l = rlast;
          @(negedge clk);
          chk("r_stall_data", rdata, d);
          chk("r_stall_last", rlast, l);
        end
      end
      rbuf[i] = rdata; rrbuf[i] = rresp; rlbuf[i] = rlast;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0;
    arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0;
    awprot = '0; awvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0104, 32'hA5A5_A5A5, 4'hF, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0104, 32'h1234_5678, 4'h6, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'hA534_56A5};
    vecs[5] = '{1'b1, 32'h0001_0104, 32'h0BAD_F00D, 4'hF, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'h0BAD_F00D};
    vecs[7] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 32'h0004_0100, 32'h0,         4'h0, 32'hDEAD_BEEF};

    repeat (3) @(negedge clk);
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_wready", wready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("arready_after_rst", arready, 1'b1);
    chk("awready_after_rst", awready, 1'b1);
    chk("wready_before_aw", wready, 1'b0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) begin
        wbuf[0] = vecs[i].data; sbuf[0] = vecs[i].strb;
        do_write(4'(i), vecs[i].addr, 4'd0, 3'd2, BurstIncr, 1);
        chk($sformatf("vec%0d_bresp", i), got_bresp, vecs[i].exp);
        chk($sformatf("vec%0d_bid", i), got_bid, 4'(i));
      end else begin
        do_read(4'(i), vecs[i].addr, 4'd0, 3'd2, BurstIncr, 1'b0);
        chk($sformatf("vec%0d_rdata", i), rbuf[0], vecs[i].exp);
        chk($sformatf("vec%0d_rresp", i), rrbuf[0], RespOkay);
        chk($sformatf("vec%0d_rlast", i), rlbuf[0], 1'b1);
      end
    end

    // INCR burst write and stalled readback
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(4'h5, 32'h200, 4'd3, 3'd2, BurstIncr, 4);
    chk("incr_bresp", got_bresp, RespOkay);
    chk("incr_bid", got_bid, 4'h5);
    do_read(4'h6, 32'h200, 4'd3, 3'd2, BurstIncr, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_rdata%0d", i), rbuf[i], 32'(i + 1));
      chk($sformatf("incr_rlast%0d", i), rlbuf[i], (i == 3));
    end

    // WRAP read starting at the last word of a 16-byte window
    do_read(4'h7, 32'h20C, 4'd3, 3'd2, BurstWrap, 1'b0);
    chk("wrap_b0", rbuf[0], 32'd4);
    chk("wrap_b1", rbuf[1], 32'd1);
    chk("wrap_b2", rbuf[2], 32'd2);
    chk("wrap_b3", rbuf[3], 32'd3);

    // FIXED burst with byte strobes
    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'hF;
    do_write(4'h1, 32'h300, 4'd0, 3'd2, BurstIncr, 1);
    wbuf[0] = 32'h0000_00AA; sbuf[0] = 4'h1;
    wbuf[1] = 32'hBB00_0000; sbuf[1] = 4'h8;
    do_write(4'h2, 32'h300, 4'd1, 3'd2, BurstFixed, 2);
    chk("fixed_bresp", got_bresp, RespOkay);
    do_read(4'h2, 32'h300, 4'd0, 3'd2, BurstIncr, 1'b0);
    chk("fixed_rdata", rbuf[0], 32'hBB22_33AA);

    // Oversize read: two beats, SLVERR, zero data
    do_read(4'h3, 32'h300, 4'd1, 3'd3, BurstIncr, 1'b0);
    chk("err_rd_resp0", rrbuf[0], RespSlverr);
    chk("err_rd_resp1", rrbuf[1], RespSlverr);
    chk("err_rd_data0", rbuf[0], 32'h0);
    chk("err_rd_last0", rlbuf[0], 1'b0);
    chk("err_rd_last1", rlbuf[1], 1'b1);

    // Short write: wlast on the first of two beats
    wbuf[0] = 32'h1111; wbuf[1] = 32'h2222; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(4'h4, 32'h400, 4'd1, 3'd2, BurstIncr, 2);
    wbuf[0] = 32'h3333;
    do_write(4'h4, 32'h400, 4'd1, 3'd2, BurstIncr, 1);
    chk("short_bresp", got_bresp, RespSlverr);
    do_read(4'h4, 32'h400, 4'd1, 3'd2, BurstIncr, 1'b0);
    chk("short_word0", rbuf[0], 32'h3333);
    chk("short_word1", rbuf[1], 32'h2222);

    // Long write: second beat beyond len is dropped
    wbuf[0] = 32'h5555; wbuf[1] = 32'h5050;
    do_write(4'h8, 32'h500, 4'd1, 3'd2, BurstIncr, 2);
    wbuf[0] = 32'h6666; wbuf[1] = 32'h7777;
    do_write(4'h8, 32'h500, 4'd0, 3'd2, BurstIncr, 2);
    chk("long_bresp", got_bresp, RespSlverr);
    // Reserved burst type: no RAM access
    wbuf[0] = 32'h9999;
    do_write(4'h9, 32'h500, 4'd0, 3'd2, 2'b11, 1);
    chk("rsvd_bresp", got_bresp, RespSlverr);
    chk("rsvd_bid", got_bid, 4'h9);
    do_read(4'h8, 32'h500, 4'd1, 3'd2, BurstIncr, 1'b0);
    chk("long_word0", rbuf[0], 32'h6666);
    chk("long_word1", rbuf[1], 32'h5050);

    // Reset during the data phase of a len7 read
    arid = 4'h9; araddr = 32'h200; arlen = 4'd7; arsize = 3'd2; arburst = BurstIncr;
    arvalid = 1'b1;
    begin
      int cnt;
      cnt = 0;
      while (!arready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) timeout("rst_ar_wait");
    end
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre_rvalid", rvalid, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_rvalid", rvalid, 1'b0);
    chk("rst_mid_rid", rid, 4'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_rlast", rlast, 1'b0);
    chk("rst_mid_arready", arready, 1'b0);
    chk("rst_mid_awready", awready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rel_arready0", arready, 1'b0);
    @(negedge clk);
    chk("rst_rel_arready1", arready, 1'b1);
    do_read(4'hA, 32'h20C, 4'd0, 3'd2, BurstIncr, 1'b0);
    chk("rst_ram_intact", rbuf[0], 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
